// File: rtl/mcpu_ctrl_if.sv
// rtl/mcpu_ctrl_if.sv - instruction fields, memory/IO handshake and datapath controls of mcpu_ctrl
interface mcpu_ctrl_if;
    logic [5:0] OPcode;
    logic [5:0] Fun;
    logic       zero;
    logic       MIO_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       mem_w;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ext_zero;
    logic [1:0] PCSource;
    logic [2:0] ALU_Control;
    logic       CPU_MIO;
    logic [3:0] state;

    modport master (
        input  OPcode, Fun, zero, MIO_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ext_zero, PCSource,
               ALU_Control, CPU_MIO, state
    );

    modport slave (
        output OPcode, Fun, zero, MIO_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ext_zero, PCSource,
               ALU_Control, CPU_MIO, state
    );
endinterface

// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multi-cycle MIPS control FSM (Moore); MCPU_ITYPE_EN enables addi/andi/ori/slti
module mcpu_ctrl (
    input  logic         clk,
    input  logic         reset,
    mcpu_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        ST_IF       = 4'd0,
        ST_ID       = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_LW_WB    = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EX     = 4'd6,
        ST_R_WB     = 4'd7,
        ST_BEQ_EX   = 4'd8,
        ST_J_EX     = 4'd9,
        ST_I_EX     = 4'd10,
        ST_I_WB     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_w;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic [2:0] alu_control;
        logic       cpu_mio;
    } ctrl_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q;
    state_t     state_n;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic [2:0] r_alu;
    logic       r_known;
    logic [2:0] i_alu;
    logic       i_ext;

    // R-type decode is re-evaluated in R_WB; IR is frozen so the result holds.
    always_comb begin
        r_alu   = ALU_ADD;
        r_known = 1'b1;
        case (bus.Fun)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            6'b100111: r_alu = ALU_NOR;
            6'b100110: r_alu = ALU_XOR;
            6'b000010: r_alu = ALU_SRL;
            default:   r_known = 1'b0;
        endcase
    end

    always_comb begin
        i_alu = ALU_ADD;
        i_ext = 1'b0;
        case (bus.OPcode)
            6'b001100: begin i_alu = ALU_AND; i_ext = 1'b1; end
            6'b001101: begin i_alu = ALU_OR;  i_ext = 1'b1; end
            6'b001010: i_alu = ALU_SLT;
            default:   i_alu = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IF;
        else       state_q <= state_n;
    end

    always_comb begin
        ctrl    = '0;
        state_n = ST_IF;
        case (state_q)
            ST_IF: begin
                ctrl.mem_read    = 1'b1;
                ctrl.cpu_mio     = 1'b1;
                ctrl.alu_src_b   = 2'b01;
                ctrl.alu_control = ALU_ADD;
                ctrl.ir_write    = bus.MIO_ready;
                ctrl.pc_write    = bus.MIO_ready;
                state_n          = bus.MIO_ready ? ST_ID : ST_IF;
            end
            ST_ID: begin
                ctrl.alu_src_b   = 2'b11;
                ctrl.alu_control = ALU_ADD;
                case (bus.OPcode)
                    6'b100011, 6'b101011: state_n = ST_MEM_ADDR;
                    6'b000000:            state_n = ST_R_EX;
                    6'b000100:            state_n = ST_BEQ_EX;
                    6'b000010:            state_n = ST_J_EX;
`ifdef MCPU_ITYPE_EN
                    6'b001000, 6'b001100,
                    6'b001101, 6'b001010: state_n = ST_I_EX;
`endif
                    default:              state_n = ST_IF;
                endcase
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = 2'b10;
                ctrl.alu_control = ALU_ADD;
                state_n          = (bus.OPcode == 6'b100011) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.cpu_mio  = 1'b1;
                state_n       = bus.MIO_ready ? ST_LW_WB : ST_MEM_RD;
            end
            ST_LW_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.iord    = 1'b1;
                ctrl.mem_w   = 1'b1;
                ctrl.cpu_mio = 1'b1;
                state_n      = bus.MIO_ready ? ST_IF : ST_MEM_WR;
            end
            ST_R_EX: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_control = r_alu;
                state_n          = r_known ? ST_R_WB : ST_IF;
            end
            ST_R_WB: begin
                ctrl.reg_dst     = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = r_alu;
            end
            ST_BEQ_EX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_control   = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            ST_J_EX: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
`ifdef MCPU_ITYPE_EN
            ST_I_EX: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = 2'b10;
                ctrl.alu_control = i_alu;
                ctrl.ext_zero    = i_ext;
                state_n          = ST_I_WB;
            end
            ST_I_WB: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = i_alu;
                ctrl.ext_zero    = i_ext;
            end
`endif
            default: state_n = ST_IF;
        endcase
    end

    // Reset masks every strobe so an abandoned store or writeback never fires.
    assign ctrl_out        = reset ? '0 : ctrl;
    assign bus.PCWrite     = ctrl_out.pc_write;
    assign bus.PCWriteCond = ctrl_out.pc_write_cond;
    assign bus.IorD        = ctrl_out.iord;
    assign bus.MemRead     = ctrl_out.mem_read;
    assign bus.mem_w       = ctrl_out.mem_w;
    assign bus.IRWrite     = ctrl_out.ir_write;
    assign bus.RegDst      = ctrl_out.reg_dst;
    assign bus.MemtoReg    = ctrl_out.mem_to_reg;
    assign bus.RegWrite    = ctrl_out.reg_write;
    assign bus.ALUSrcA     = ctrl_out.alu_src_a;
    assign bus.ALUSrcB     = ctrl_out.alu_src_b;
    assign bus.ext_zero    = ctrl_out.ext_zero;
    assign bus.PCSource    = ctrl_out.pc_source;
    assign bus.ALU_Control = ctrl_out.alu_control;
    assign bus.CPU_MIO     = ctrl_out.cpu_mio;
    assign bus.state       = reset ? 4'd0 : state_q;
endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb/tb_mcpu_ctrl.sv - scoreboard bench for mcpu_ctrl; honours MCPU_ITYPE_EN
module tb_mcpu_ctrl;
    logic clk;
    logic reset;
    mcpu_ctrl_if bus ();

    mcpu_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] o;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Field order: PCWrite PCWriteCond IorD MemRead mem_w IRWrite RegDst MemtoReg
    // RegWrite ALUSrcA ALUSrcB ext_zero PCSource ALU_Control CPU_MIO
    function automatic logic [18:0] mk(
        input logic pcw, pcwc, iord, mrd, mw, irw, rdst, m2r, rw, srca,
        input logic [1:0] srcb, input logic ez, input logic [1:0] psrc,
        input logic [2:0] alu, input logic mio);
        return {pcw, pcwc, iord, mrd, mw, irw, rdst, m2r, rw, srca, srcb, ez, psrc, alu, mio};
    endfunction

    logic [18:0] o_zero, o_if1, o_if0, o_id, o_rex_sub, o_rwb_sub, o_rex_add;
    logic [18:0] o_maddr, o_mrd, o_lwwb, o_mwr, o_beq, o_j, o_iex_ori, o_iwb_ori;
    logic [18:0] act;

    assign act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.mem_w,
                  bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ext_zero, bus.PCSource, bus.ALU_Control, bus.CPU_MIO};

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            checks++;
            if (bus.state !== e.st) begin
                errors++;
                $display("FAIL state: got %0d expected %0d at %0t", bus.state, e.st, $time);
            end
            checks++;
            if (act !== e.o) begin
                errors++;
                $display("FAIL outputs(state %0d): got %b expected %b at %0t", e.st, act, e.o, $time);
            end
        end
    end

    task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic [3:0] st, input logic [18:0] o);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.OPcode    = op;
        bus.Fun       = fn;
        bus.MIO_ready = rdy;
        expq.push_back({st, o});
    endtask

    initial begin
        o_zero    = '0;
        o_if1     = mk(1,0,0,1,0,1,0,0,0,0,2'b01,0,2'b00,3'b010,1);
        o_if0     = mk(0,0,0,1,0,0,0,0,0,0,2'b01,0,2'b00,3'b010,1);
        o_id      = mk(0,0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,3'b010,0);
        o_rex_sub = mk(0,0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,3'b110,0);
        o_rwb_sub = mk(0,0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,3'b110,0);
        o_rex_add = mk(0,0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,3'b010,0);
        o_maddr   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b010,0);
        o_mrd     = mk(0,0,1,1,0,0,0,0,0,0,2'b00,0,2'b00,3'b000,1);
        o_lwwb    = mk(0,0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,3'b000,0);
        o_mwr     = mk(0,0,1,0,1,0,0,0,0,0,2'b00,0,2'b00,3'b000,1);
        o_beq     = mk(0,1,0,0,0,0,0,0,0,1,2'b00,0,2'b01,3'b110,0);
        o_j       = mk(1,0,0,0,0,0,0,0,0,0,2'b00,0,2'b10,3'b000,0);
        o_iex_ori = mk(0,0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,3'b001,0);
        o_iwb_ori = mk(0,0,0,0,0,0,0,0,1,0,2'b00,1,2'b00,3'b001,0);

        reset = 1'b1; bus.OPcode = '0; bus.Fun = '0; bus.zero = 1'b1; bus.MIO_ready = 1'b1;

        // reset held two cycles
        step(1, 6'h00, 6'h00, 1, 4'd0, o_zero);
        step(1, 6'h00, 6'h00, 1, 4'd0, o_zero);

        // R-type sub, with one fetch stall first
        step(0, 6'b000000, 6'b100010, 0, 4'd0, o_if0);
        step(0, 6'b000000, 6'b100010, 1, 4'd0, o_if1);
        step(0, 6'b000000, 6'b100010, 1, 4'd1, o_id);
        step(0, 6'b000000, 6'b100010, 1, 4'd6, o_rex_sub);
        step(0, 6'b000000, 6'b100010, 1, 4'd7, o_rwb_sub);

        // lw with two MEM_RD wait cycles
        step(0, 6'b100011, 6'h00, 1, 4'd0, o_if1);
        step(0, 6'b100011, 6'h00, 1, 4'd1, o_id);
        step(0, 6'b100011, 6'h00, 1, 4'd2, o_maddr);
        step(0, 6'b100011, 6'h00, 0, 4'd3, o_mrd);
        step(0, 6'b100011, 6'h00, 0, 4'd3, o_mrd);
        step(0, 6'b100011, 6'h00, 1, 4'd3, o_mrd);
        step(0, 6'b100011, 6'h00, 1, 4'd4, o_lwwb);

        // beq, then illegal opcode
        step(0, 6'b000100, 6'h00, 1, 4'd0, o_if1);
        step(0, 6'b000100, 6'h00, 1, 4'd1, o_id);
        step(0, 6'b000100, 6'h00, 1, 4'd8, o_beq);
        step(0, 6'b111111, 6'h00, 1, 4'd0, o_if1);
        step(0, 6'b111111, 6'h00, 1, 4'd1, o_id);

        // j
        step(0, 6'b000010, 6'h00, 1, 4'd0, o_if1);
        step(0, 6'b000010, 6'h00, 1, 4'd1, o_id);
        step(0, 6'b000010, 6'h00, 1, 4'd9, o_j);

        // R-type with unknown Fun: add, no writeback
        step(0, 6'b000000, 6'b111111, 1, 4'd0, o_if1);
        step(0, 6'b000000, 6'b111111, 1, 4'd1, o_id);
        step(0, 6'b000000, 6'b111111, 1, 4'd6, o_rex_add);

        // sw completing normally
        step(0, 6'b101011, 6'h00, 1, 4'd0, o_if1);
        step(0, 6'b101011, 6'h00, 1, 4'd1, o_id);
        step(0, 6'b101011, 6'h00, 1, 4'd2, o_maddr);
        step(0, 6'b101011, 6'h00, 1, 4'd5, o_mwr);

        // sw abandoned by reset while waiting in MEM_WR
        step(0, 6'b101011, 6'h00, 1, 4'd0, o_if1);
        step(0, 6'b101011, 6'h00, 1, 4'd1, o_id);
        step(0, 6'b101011, 6'h00, 1, 4'd2, o_maddr);
        step(0, 6'b101011, 6'h00, 0, 4'd5, o_mwr);
        step(1, 6'b101011, 6'h00, 1, 4'd0, o_zero);
        step(0, 6'b101011, 6'h00, 1, 4'd0, o_if1);

        // ori
        step(0, 6'b001101, 6'h00, 1, 4'd1, o_id);
`ifdef MCPU_ITYPE_EN
        step(0, 6'b001101, 6'h00, 1, 4'd10, o_iex_ori);
        step(0, 6'b001101, 6'h00, 1, 4'd11, o_iwb_ori);
`endif
        step(0, 6'b000000, 6'h00, 1, 4'd0, o_if1);

        repeat (3) @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
